// File: rtl/multicycle_controller_fsm.sv
// Multicycle ARM-subset control unit: a state machine with per-state datapath
// controls, a memory wait counter, condition evaluation and stored NZCV flags.
module multicycle_controller_fsm #(
    parameter int MEM_LAT   = 1,
    parameter bit USE_READY = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic [3:0]  ALU_FLAGS,
    input  logic        MEM_READY,
    output logic        WD3Src,
    output logic        A3Src,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        FlagWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  STATE,
    output logic [3:0]  FLAGS_Q,
    output logic        ILLEGAL
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  wait_cnt;
    logic        done;
    logic        illegal_set;
    logic        cond_ok;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm;
    logic        link;
    logic [3:0]  cmd;
    logic        ls_bit;

    assign cond   = INSTRUCTION[31:28];
    assign op     = INSTRUCTION[27:26];
    assign imm    = INSTRUCTION[25];
    assign link   = INSTRUCTION[24];
    assign cmd    = INSTRUCTION[24:21];
    assign ls_bit = INSTRUCTION[20];

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf && !z;
            4'h9:    cond_pass = !cf || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign cond_ok = cond_pass(cond, FLAGS_Q);
    // MEM_READY only matters through done, which only the wait states consult
    assign done    = USE_READY ? MEM_READY : (wait_cnt == LAT_M1);
    assign STATE   = state;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= FETCH;
            wait_cnt <= 4'd0;
            FLAGS_Q  <= 4'd0;
            ILLEGAL  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                wait_cnt <= 4'd0;
            else if (!USE_READY && !done)
                wait_cnt <= wait_cnt + 4'd1;
            if (FlagWrite)
                FLAGS_Q <= ALU_FLAGS;
            if (illegal_set)
                ILLEGAL <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = FETCH;
        illegal_set = 1'b0;
        WD3Src      = 1'b0;
        A3Src       = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        FlagWrite   = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b11;
                ResultSrc = 2'b10;
                IRWrite   = done;
                PCWrite   = done;
                state_nx  = done ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB   = 2'b11;
                ResultSrc = 2'b10;
                A3Src     = (op == 2'b10);
                // Illegal encodings are flagged even when the condition fails
                if (cond == 4'hF || op == 2'b11) begin
                    illegal_set = 1'b1;
                    state_nx    = FETCH;
                end else if (!cond_ok)
                    state_nx = FETCH;
                else if (op == 2'b00)
                    state_nx = imm ? EXECI : EXECR;
                else if (op == 2'b01)
                    state_nx = MEMADR;
                else
                    state_nx = BRANCH;
            end
            MEMADR: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b01;
                state_nx = ls_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc   = 1'b1;
                state_nx = done ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b01;
                state_nx  = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = done;
                state_nx = done ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA  = 2'b01;
                state_nx = ALUWB;
            end
            EXECI: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b01;
                state_nx = ALUWB;
            end
            ALUWB: begin
                // TST/TEQ/CMP/CMN (10xx) only update flags
                RegWrite  = (cmd[3:2] != 2'b10);
                FlagWrite = ls_bit;
                state_nx  = FETCH;
            end
            BRANCH: begin
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                WD3Src    = link;
                A3Src     = link;
                RegWrite  = link;
                state_nx  = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

endmodule

// File: doc/multicycle_controller_fsm.md
MULTICYCLE_CONTROLLER_FSM -- requirements
Module: multicycle_controller_fsm

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning the number of cycles per memory access (1..15) when USE_READY=0.
REQ-002 SHALL have parameter USE_READY, default 0, meaning 1 = memory states end on MEM_READY and MEM_LAT is ignored.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous active-low reset, sampled on the CLK rising edge.
REQ-005 SHALL have port INSTRUCTION, input, 32, instruction register contents: cond=[31:28], op=[27:26], Im=[25], Link=[24], cmd=[24:21], L/S=[20].
REQ-006 SHALL have port ALU_FLAGS, input, 4, the live ALU NZCV, in bit order N=[3], Z=[2], C=[1], V=[0].
REQ-007 SHALL have port MEM_READY, input, 1, memory-done strobe, used only when USE_READY=1.
REQ-008 SHALL have outputs WD3Src, A3Src, IRWrite, PCWrite, AdrSrc, MemWrite, RegWrite and FlagWrite, 1 bit each, carrying the datapath controls.
REQ-009 SHALL have outputs ALUSrcA, ALUSrcB and ResultSrc, 2 bits each, carrying the datapath mux selects.
REQ-010 SHALL have outputs STATE (4 bits, current state code), FLAGS_Q (4 bits, stored NZCV) and ILLEGAL (1 bit, sticky illegal-instruction flag).

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8 and BRANCH=9; codes 10..15 SHALL go to FETCH on the next cycle with all write enables at 0.
REQ-012 SHALL drive outputs combinationally from STATE and INSTRUCTION; any signal not listed for a state is 0 (2-bit selects 00).
REQ-013 SHALL run a wait counter in FETCH, MEMREAD and MEMWRITE, cleared on state entry; "done" = (count==MEM_LAT-1) when USE_READY=0, else MEM_READY=1.
REQ-014 SHALL drive FETCH as ALUSrcA=00, ALUSrcB=11, ResultSrc=10, with IRWrite=PCWrite=1 only on the done cycle; FETCH SHALL stay put until done, then go to DECODE.
REQ-015 SHALL drive DECODE as ALUSrcA=00, ALUSrcB=11, ResultSrc=10, with A3Src=1 when op=10.
REQ-016 SHALL evaluate the condition in DECODE against FLAGS_Q: EQ..AL use standard ARM encodings 0000..1110; cond=1111 is illegal.
REQ-017 SHALL make DECODE transitions as follows: condition false -> FETCH; op=00 -> EXECI if Im=1, else EXECR; op=01 -> MEMADR; op=10 -> BRANCH; op=11 or cond=1111 -> FETCH with ILLEGAL set to 1.
REQ-018 SHALL drive MEMADR as ALUSrcA=01, ALUSrcB=01, then go to MEMREAD if L=1, else MEMWRITE.
REQ-019 SHALL drive MEMREAD as AdrSrc=1 and hold until done, then go to MEMWB; MEMWB SHALL drive RegWrite=1, ResultSrc=01, then go to FETCH.
REQ-020 SHALL drive MEMWRITE as AdrSrc=1, with MemWrite=1 only on the done cycle, then go to FETCH.
REQ-021 SHALL drive EXECR as ALUSrcA=01, ALUSrcB=00, and EXECI as ALUSrcA=01, ALUSrcB=01; both SHALL go to ALUWB.
REQ-022 SHALL drive ALUWB as ResultSrc=00, with RegWrite=1 unless cmd is TST(1000), TEQ(1001), CMP(1010) or CMN(1011); FlagWrite SHALL equal the S bit; ALUWB then goes to FETCH.
REQ-023 SHALL load FLAGS_Q from ALU_FLAGS on the rising edge where FlagWrite=1; FLAGS_Q SHALL be unchanged otherwise.
REQ-024 SHALL drive BRANCH as PCWrite=1, ALUSrcA=00, ALUSrcB=01, ResultSrc=10; when Link=1 it SHALL also drive WD3Src=1, A3Src=1, RegWrite=1; BRANCH then goes to FETCH.
REQ-025 SHALL keep ILLEGAL at 1 once set, until reset; ILLEGAL SHALL NOT block later instructions.
REQ-026 SHALL never assert MemWrite and RegWrite in the same cycle, and SHALL assert IRWrite only in FETCH.
REQ-027 SHALL ignore MEM_READY outside FETCH, MEMREAD and MEMWRITE, and SHALL ignore it entirely when USE_READY=0.

Reset
REQ-028 SHALL, with RESET=0 at a rising edge, set STATE=FETCH, wait counter=0, FLAGS_Q=0000 and ILLEGAL=0 regardless of the current state.
REQ-029 SHALL, on reset mid-access (e.g. in MEMWRITE before done), drive MemWrite=0 from the cycle after the reset edge and issue no further writes until a new FETCH completes.

Verification
REQ-030 SHALL cover, with MEM_LAT=1, ADD r-type (op=00, Im=0, cond=1110): STATE sequence 0,1,6,8,0; RegWrite=1 only in state 8.
REQ-031 SHALL cover, with MEM_LAT=3, LDR (op=01, L=1): FETCH lasts 3 cycles with IRWrite=1 only on the 3rd; MEMREAD lasts 3 cycles; then MEMWB has RegWrite=1, ResultSrc=01.
REQ-032 SHALL cover CMP with S=1 and ALU_FLAGS=0100: ALUWB has RegWrite=0, FlagWrite=1, FLAGS_Q=0100; the following BEQ reaches BRANCH with PCWrite=1.
REQ-033 SHALL cover BEQ with FLAGS_Q=0000: DECODE -> FETCH directly, with PCWrite, RegWrite and MemWrite 0 throughout DECODE.
REQ-034 SHALL cover, with USE_READY=1, STR and MEM_READY held low for 5 cycles then pulsed: MEMWRITE lasts 6 cycles with MemWrite=1 only in the 6th.
REQ-035 SHALL cover op=11, then RESET=0 during the next MEMWRITE: ILLEGAL=1 after the op=11 DECODE, then ILLEGAL=0, STATE=0 and MemWrite=0 after the reset edge.
